// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared neuron datapath widths and activation saturation limit
package nn_pkg;

    localparam int DEF_IN_W  = 23;
    localparam int DEF_OUT_W = 12;
    localparam int DEF_SHIFT = 8;

    // Largest activation the next layer's signed multiplicand can hold
    function automatic int act_sat(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    localparam int ACT_SAT = act_sat(DEF_OUT_W);

endpackage

// File: rtl/act_fifo.sv
// rtl/act_fifo.sv - first-word fall-through activation FIFO with occupancy output
module act_fifo
    import nn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // A full FIFO still takes a write when the head leaves on the same edge
    always_comb begin
        full     = (level == (AW+1)'(DEPTH));
        rd_valid = !rst && (level != '0);
        rd_data  = rd_valid ? mem[rd_ptr] : '0;
        wr_ready = !full || rd_ready;
        pop      = rd_valid && rd_ready;
        push     = wr_valid && wr_ready;
    end

    // Storage is deliberately left unreset; only the pointers define contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/neuron_activation.sv
// rtl/neuron_activation.sv - ReLU, round, saturate and buffer neuron results
module neuron_activation
    import nn_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = 4,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  data_in,
    output logic             act_valid,
    input  logic             act_ready,
    output logic [OUT_W-1:0] act_data,
    output logic [LW-1:0]    fifo_level,
    output logic             overflow,
    output logic [7:0]       out_count
);

    localparam logic [IN_W:0]  HALF     = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic [IN_W:0]  SAT_WIDE = (IN_W+1)'(act_sat(OUT_W));
    localparam logic [OUT_W-1:0] SAT    = OUT_W'(act_sat(OUT_W));

    logic [IN_W:0]    relu_x;
    logic [IN_W:0]    rounded;
    logic [IN_W:0]    shifted;
    logic [OUT_W-1:0] act_next;
    logic             s1_valid;
    logic [OUT_W-1:0] s1_data;
    logic             fifo_wr_ready;
    logic             pop;

    // One extra bit keeps the rounding add from wrapping at the positive limit
    always_comb begin
        relu_x   = data_in[IN_W-1] ? '0 : {1'b0, data_in};
        rounded  = relu_x + HALF;
        shifted  = rounded >> SHIFT;
        act_next = (shifted > SAT_WIDE) ? SAT : shifted[OUT_W-1:0];
        pop      = act_valid && act_ready;
    end

    // Stage-1 register; valid_in seen during reset is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_in;
        end
        if (valid_in) begin
            s1_data <= act_next;
        end
    end

    // Sticky drop flag and popped-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            out_count <= '0;
        end else begin
            if (s1_valid && !fifo_wr_ready) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                out_count <= out_count + 8'd1;
            end
        end
    end

    act_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (s1_valid),
        .wr_data  (s1_data),
        .wr_ready (fifo_wr_ready),
        .rd_valid (act_valid),
        .rd_ready (act_ready),
        .rd_data  (act_data),
        .level    (fifo_level)
    );

endmodule

// File: doc/neuron_activation.md
NEURON_ACTIVATION -- requirements
Module: neuron_activation

Interface
REQ-001 Parameter: IN_W, 23, width of the neuron accumulator result.
REQ-002 Parameter: OUT_W, 12, width of the activation output (next-layer multiplicand).
REQ-003 Parameter: SHIFT, 8, fractional bits removed during requantization.
REQ-004 Parameter: DEPTH, 4, output FIFO depth (power of two, >=2).
REQ-005 One clock, reset synchronous active-high; clock and reset ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 valid_in  input  1  data_in qualifier, driven by the neuron's valid_out; no backpressure.
REQ-009 data_in  input  IN_W  signed two's-complement accumulator result.
REQ-010 act_valid  output  1  FIFO head valid.
REQ-011 act_ready  input  1  consumer ready.
REQ-012 act_data  output  OUT_W  unsigned activation value, range 0..2^(OUT_W-1)-1.
REQ-013 fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag for a dropped result.
REQ-015 out_count  output  8  count of words popped, wraps 255->0.

Function
REQ-016 The stage-1 register SHALL capture, on each edge with valid_in=1: ReLU (data_in<=0 gives 0), then (x + 2^(SHIFT-1)) >>> SHIFT computed in IN_W+1 bits, then saturation to 2^(OUT_W-1)-1 (0x7FF).
REQ-017 Stage-1 valid SHALL follow valid_in with exactly one cycle of delay.
REQ-018 Stage-1 output SHALL be written into the FIFO on the following edge, so act_valid rises two edges after valid_in is sampled when the FIFO is empty.
REQ-019 Handshake: a pop SHALL occur on an edge where act_valid=1 and act_ready=1; act_data SHALL remain stable while act_valid=1 and act_ready=0.
REQ-020 act_data SHALL present the FIFO head driven from storage (no extra register), and SHALL be 0 when the FIFO is empty.
REQ-021 Full FIFO with a simultaneous pop SHALL accept the write; fifo_level SHALL remain DEPTH.
REQ-022 Empty FIFO with stage-1 valid SHALL write only; a pop is impossible because act_valid=0.
REQ-023 Full FIFO with stage-1 valid and no pop SHALL drop the word, set overflow=1, and leave FIFO contents unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 fifo_level SHALL equal writes minus pops, range 0..DEPTH.
REQ-026 out_count SHALL increment on every pop.
REQ-027 overflow SHALL clear only on rst.
REQ-028 Back-to-back valid_in every cycle SHALL be sustained at one word per cycle while act_ready=1.

Reset
REQ-029 When rst=1 at an edge, the block SHALL clear stage-1 valid, pointers, fifo_level, overflow, and out_count to 0.
REQ-030 During reset, act_valid=0 and act_data=0.
REQ-031 Reset mid-stream SHALL discard all in-flight and buffered words.
REQ-032 valid_in sampled while rst=1 SHALL be ignored.
REQ-033 FIFO storage contents are not reset.

Structure
REQ-034 Package nn_pkg SHALL hold IN_W, OUT_W, SHIFT defaults and the act_sat(max) constant shared with the neuron.
REQ-035 One sub-module, act_fifo (DEPTH x OUT_W, level output, first-word fall-through), SHALL hold the buffering.
REQ-036 ReLU/round/saturate logic SHALL stay in the top level.

Verification
REQ-037 Input data_in=0x000E80 (14.5) -> act_data=0x00F two edges later.
REQ-038 Input 0x00017F -> 0x001; input 0x000180 -> 0x002 (round-half-up boundary).
REQ-039 Inputs 0x7FFFFF (-1) and 0x400000 (most negative) -> 0x000 (ReLU); input 0x3FFFFF -> 0x7FF (saturation).
REQ-040 act_ready=0, six consecutive inputs 1..6 (each x 256) -> fifo_level=4, overflow=1, pops return 1,2,3,4, out_count=4.
REQ-041 FIFO full, one input with act_ready=1 on the same edge -> level stays 4, no overflow, order preserved.
REQ-042 rst asserted with 3 words buffered -> next edge act_valid=0, fifo_level=0, overflow=0, out_count=0.
